// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer beside the EX-stage ALU.
// One bit per cycle shift-add multiply / restoring divide into HI/LO.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcAE,
  input  logic [WIDTH-1:0] srcBE,
  input  logic             flushE,
  input  logic             hiloReadD,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] hiIn,
  input  logic [WIDTH-1:0] loIn,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] RUN  = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [1:0]       opR;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic             negQ;
  logic             negR;
  logic             divZero;

  logic             isDiv;
  logic             isSigned;
  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   addSum;
  logic [WIDTH:0]   shifted;
  logic             geq;
  logic [WIDTH-1:0] diff;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0] quotFix;
  logic [WIDTH-1:0] remFix;

  assign isDiv    = opR[1];
  assign isSigned = ~opR[0];
  assign aNeg     = isSigned & srcA[WIDTH-1];
  assign bNeg     = isSigned & srcB[WIDTH-1];
  assign absA     = aNeg ? -srcA : srcA;
  assign absB     = bNeg ? -srcB : srcB;

  // one loop step: shift-add for multiply, compare-subtract for divide
  always_comb begin
    addSum  = {1'b0, acc} + (q[0] ? {1'b0, dvs} : '0);
    shifted = {acc, q[WIDTH-1]};
    geq     = shifted >= {1'b0, dvs};
    diff    = shifted[WIDTH-1:0] - dvs;
  end

  // sign correction of the magnitude result
  always_comb begin
    prodFix = negQ ? -{acc, q} : {acc, q};
    quotFix = negQ ? -q : q;
    remFix  = negR ? -acc : acc;
  end

  // sequencer state and loop datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      opR     <= '0;
      srcA    <= '0;
      srcB    <= '0;
      acc     <= '0;
      q       <= '0;
      dvs     <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divZero <= 1'b0;
    end else if (flushE) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (startE) begin
            opR   <= opE;
            srcA  <= srcAE;
            srcB  <= srcBE;
            state <= PREP;
          end else begin
            state <= IDLE;
          end
        end
        PREP: begin
          cnt  <= '0;
          acc  <= '0;
          negQ <= aNeg ^ bNeg;
          negR <= aNeg;
          if (isDiv) begin
            q       <= absA;
            dvs     <= absB;
            divZero <= (srcB == '0);
            state   <= (srcB == '0) ? FIX : RUN;
          end else begin
            q       <= absB;
            dvs     <= absA;
            divZero <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (isDiv) begin
            acc <= geq ? diff : shifted[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], geq};
          end else begin
            {acc, q} <= {addSum, q[WIDTH-1:1]};
          end
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX:     state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // HI/LO: loop result on leaving FIX, else MTHI/MTLO when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX && !flushE) begin
      if (!isDiv) begin
        {hi, lo} <= prodFix;
      end else if (divZero) begin
        hi <= srcA;
        lo <= '1;
      end else begin
        hi <= remFix;
        lo <= quotFix;
      end
    end else if (!busy) begin
      if (hiWrite) hi <= hiIn;
      if (loWrite) lo <= loIn;
    end
  end

  assign busy  = (state == PREP) || (state == RUN) || (state == FIX);
  assign done  = (state == DONE);
  assign stall = busy & (startE | hiloReadD | hiWrite | loWrite);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer.
// Vector table plus hand sequences for stall, flush and reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcAE;
  logic [31:0] srcBE;
  logic        flushE;
  logic        hiloReadD;
  logic        hiWrite;
  logic        loWrite;
  logic [31:0] hiIn;
  logic [31:0] loIn;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int nCmp = 0;
  int nBad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[10];

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .startE(startE), .opE(opE),
    .srcAE(srcAE), .srcBE(srcBE), .flushE(flushE),
    .hiloReadD(hiloReadD), .hiWrite(hiWrite), .loWrite(loWrite),
    .hiIn(hiIn), .loIn(loIn), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    startE = 1'b1;
    opE    = op;
    srcAE  = a;
    srcBE  = b;
    tick();
    startE = 1'b0;
  endtask

  // returns in the done cycle (or after the limit with cyc = -1)
  task automatic waitDone(int limit, output int cyc, output logic [2:0] bm);
    cyc = -1;
    bm  = '0;
    for (int c = 1; c <= limit; c++) begin
      if (c <= 3) bm[c-1] = busy;
      if (done) begin
        cyc = c;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int          cyc;
    int          c1;
    logic [2:0]  bm;
    logic        ok;

    vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 35};
    vecs[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 35};
    vecs[2] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       35};
    vecs[3] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 35};
    vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 35};
    vecs[5] = '{2'b10, 32'd10,       32'd0,        32'd10,       32'hFFFFFFFF, 3};
    vecs[6] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 35};
    vecs[7] = '{2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 35};
    vecs[8] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 35};
    vecs[9] = '{2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 3};

    rst = 1'b1; startE = 1'b0; opE = '0; srcAE = '0; srcBE = '0;
    flushE = 1'b0; hiloReadD = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
    hiIn = '0; loIn = '0;
    tick();
    tick();
    check("rstHi", 64'(hi), 64'h0);
    check("rstLo", 64'(lo), 64'h0);
    check("rstBusy", 64'(busy), 64'h0);
    check("rstDone", 64'(done), 64'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      waitDone(60, cyc, bm);
      check($sformatf("v%0d.hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("v%0d.lo", i), 64'(lo), 64'(vecs[i].lo));
      check($sformatf("v%0d.cyc", i), 64'(cyc), 64'(vecs[i].cyc));
      check($sformatf("v%0d.busy", i), 64'(bm),
            (vecs[i].cyc == 3) ? 64'h3 : 64'h7);
      tick();
      check($sformatf("v%0d.donePulse", i), 64'(done), 64'h0);
    end

    hiWrite = 1'b1; hiIn = 32'h0000AAAA;
    loWrite = 1'b1; loIn = 32'h0000BBBB;
    tick();
    hiWrite = 1'b0; loWrite = 1'b0;
    check("mthi", 64'(hi), 64'h0000AAAA);
    check("mtlo", 64'(lo), 64'h0000BBBB);

    // held start + MFHI during RUN: stall, no restart, then back-to-back
    issue(2'b01, 32'd6, 32'd7);
    ok = 1'b1;
    c1 = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5) begin
        startE = 1'b1; opE = 2'b11; srcAE = 32'd1; srcBE = 32'd1;
        hiloReadD = 1'b1;
        #1;
        check("stallRun", 64'(stall), 64'h1);
      end else if (c > 5 && !done && stall !== 1'b1) begin
        ok = 1'b0;
      end
      if (done) begin
        c1 = c;
        break;
      end
      tick();
    end
    check("stallHeld", 64'(ok), 64'h1);
    check("stallCyc", 64'(c1), 64'd35);
    check("stallLo", 64'(lo), 64'd42);
    check("stallHi", 64'(hi), 64'd0);
    check("stallDone", 64'(stall), 64'h0);
    tick();
    startE = 1'b0; hiloReadD = 1'b0;
    waitDone(60, cyc, bm);
    check("b2bCyc", 64'(cyc), 64'd35);
    check("b2bLo", 64'(lo), 64'd1);
    check("b2bHi", 64'(hi), 64'd0);
    tick();

    hiWrite = 1'b1; hiIn = 32'h0000AAAA;
    loWrite = 1'b1; loIn = 32'h0000BBBB;
    tick();
    hiWrite = 1'b0; loWrite = 1'b0;

    // flush in cycle 10
    issue(2'b01, 32'd2, 32'd3);
    ok = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (done) ok = 1'b0;
      if (c == 10) flushE = 1'b1;
      tick();
    end
    flushE = 1'b0;
    check("flushBusy", 64'(busy), 64'h0);
    for (int c = 0; c < 40; c++) begin
      if (done) ok = 1'b0;
      tick();
    end
    check("flushNoDone", 64'(ok), 64'h1);
    check("flushHi", 64'(hi), 64'h0000AAAA);
    check("flushLo", 64'(lo), 64'h0000BBBB);

    // reset in cycle 20
    issue(2'b00, 32'd5, 32'd9);
    for (int c = 1; c <= 20; c++) begin
      if (c == 20) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    check("rstOpHi", 64'(hi), 64'h0);
    check("rstOpLo", 64'(lo), 64'h0);
    check("rstOpBusy", 64'(busy), 64'h0);
    check("rstOpDone", 64'(done), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
